mem_access_ctrl: RTL

//  Load/store unit between the MEM pipeline stage and the byte-lane data memory.

---
 rtl/mem_pkg.sv | 42 ++++
 rtl/lane_align.sv | 38 +++
 rtl/mem_access_ctrl.sv | 108 ++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the load/store unit: op codes, memory mode, FSM states
// and the alignment rule used at request accept.
package mem_pkg;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LH  = 3'd1,
    OP_LHU = 3'd2,
    OP_LB  = 3'd3,
    OP_LBU = 3'd4,
    OP_SW  = 3'd5,
    OP_SH  = 3'd6,
    OP_SB  = 3'd7
  } op_e;

  // Mode 2'b11 clears the addressed word, so only word mode is ever driven.
  localparam logic [1:0] DM_MODE_WORD = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_EXTRACT = 3'd2,
    S_MERGE   = 3'd3,
    S_WRITE   = 3'd4,
    S_RESP    = 3'd5
  } state_e;

  function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] off);
    case (op)
      OP_LW, OP_SW:          return off != 2'b00;
      OP_LH, OP_LHU, OP_SH:  return off[0];
      OP_LB, OP_LBU, OP_SB:  return 1'b0;
      default:               return 1'b1;
    endcase
  endfunction

  function automatic logic is_load(input logic [2:0] op);
    return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
           (op == OP_LB) || (op == OP_LBU);
  endfunction

endpackage

// File: rtl/lane_align.sv
// Combinational byte-lane steering: load extraction with sign/zero extension and
// sub-word merge of store data into a previously read word (little-endian lanes).
module lane_align
  import mem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [15:0] i_wdata,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_op,
  output logic [31:0] o_rdata,
  output logic [31:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte  = i_word[{i_off, 3'b000} +: 8];
    w_half  = i_word[{i_off[1], 4'b0000} +: 16];
    o_rdata = i_word;
    case (i_op)
      OP_LB:   o_rdata = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  o_rdata = {24'h0, w_byte};
      OP_LH:   o_rdata = {{16{w_half[15]}}, w_half};
      OP_LHU:  o_rdata = {16'h0, w_half};
      default: o_rdata = i_word;
    endcase
  end

  always_comb begin
    o_merged = i_word;
    if (i_op == OP_SB)
      o_merged[{i_off, 3'b000} +: 8] = i_wdata[7:0];
    else if (i_op == OP_SH)
      o_merged[{i_off[1], 4'b0000} +: 16] = i_wdata;
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store unit between the MEM stage and a word-wide data memory. One request
// at a time; sub-word stores are done as read-modify-write of the full word.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_misalign,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_din,
  output logic              dm_we,
  output logic [1:0]        dm_mode,
  input  logic [31:0]       dm_dout
);

  state_e            r_state, w_next;
  logic [2:0]        r_op;
  logic [1:0]        r_off;
  logic [15:0]       r_wdata;
  logic [31:0]       r_rdata, r_din;
  logic [ADDR_W-1:0] r_addr;
  logic              r_misalign;
  logic              w_accept, w_mis;
  logic [31:0]       w_rdata, w_merged;

  assign w_accept = req_valid && req_ready;
  assign w_mis    = is_misaligned(req_op, req_addr[1:0]);

  lane_align u_lane (
    .i_word   (dm_dout),
    .i_wdata  (r_wdata),
    .i_off    (r_off),
    .i_op     (r_op),
    .o_rdata  (w_rdata),
    .o_merged (w_merged)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_mis)                 w_next = S_RESP;
          else if (req_op == OP_SW)  w_next = S_WRITE;
          else                       w_next = S_LOAD;
        end
      end
      S_LOAD:    w_next = is_load(r_op) ? S_EXTRACT : S_MERGE;
      S_EXTRACT: w_next = S_RESP;
      S_MERGE:   w_next = S_WRITE;
      S_WRITE:   w_next = S_RESP;
      S_RESP:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // rst_n gates the strobes directly so a store cut by reset never writes.
  always_comb begin
    req_ready = (r_state == S_IDLE) && rst_n;
    rsp_valid = (r_state == S_RESP);
    dm_we     = (r_state == S_WRITE) && rst_n;
    dm_mode   = DM_MODE_WORD;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op       <= '0;
      r_off      <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_din      <= '0;
      r_addr     <= '0;
      r_misalign <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op       <= req_op;
        r_off      <= req_addr[1:0];
        r_wdata    <= req_wdata[15:0];
        r_addr     <= {req_addr[ADDR_W-1:2], 2'b00};
        r_rdata    <= '0;
        r_misalign <= w_mis;
        if (req_op == OP_SW) r_din <= req_wdata;
      end
      if (r_state == S_EXTRACT) r_rdata <= w_rdata;
      if (r_state == S_MERGE)   r_din   <= w_merged;
    end
  end

  assign rsp_rdata    = r_rdata;
  assign rsp_misalign = r_misalign;
  assign dm_addr      = r_addr;
  assign dm_din       = r_din;

endmodule
